frame_mode_engine: RTL and testbench

//  Parametrised frame processor: collects a frame of N signed words on in_valid/in_data, latches an

---
 rtl/frame_mode_engine.sv | 264 ++++++++++++++++++++++++++
 tb/tb_frame_mode_engine.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_mode_engine.sv
// -----------------------------------------------------------------------------
// frame_mode_engine
//   Collects a frame of N signed words, latches an operation code on the first
//   beat, computes an N-word result vector in one cycle and streams it out.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset (highest priority)
//   in_valid   input beat valid; a frame is exactly N consecutive beats
//   in_data    input word, signed two's complement, DATA_W bits
//   in_mode    operation code, sampled only on the first beat of a frame
//   out_valid  result beat valid, N consecutive cycles per frame
//   out_data   result word, forced to 0 whenever out_valid is low
//   err        one-cycle pulse on a protocol violation or reserved mode
//   dbg_state  current FSM state (IDLE=0, LOAD=1, CALC=2, OUT=3)
//
// Handshake: there is no back-pressure. A beat is transferred on every rising
// edge where in_valid=1 and the engine is accepting (IDLE or LOAD); a result
// beat is presented on every cycle where out_valid=1 and must be taken then.
//
// Modes: 0 pass, 1 reverse, 2 sort ascending, 3 sort descending,
//        4 saturated prefix sum, 5 saturated offset from min, 6 running max,
//        7 (and any larger code) reserved: pass-through plus an err pulse.
// -----------------------------------------------------------------------------
module frame_mode_engine #(
   parameter int DATA_W = 9,
   parameter int N      = 6,
   parameter int MODE_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic [MODE_W-1:0] in_mode,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              err,
   output logic [1:0]        dbg_state
);

   localparam int CW = $clog2(N);
   // Prefix sums of N words need log2(N) guard bits to never wrap.
   localparam int SW = DATA_W + $clog2(N);
   localparam logic signed [SW-1:0] SAT_MAX = SW'((2 ** (DATA_W - 1)) - 1);
   localparam logic signed [SW-1:0] SAT_MIN = SW'(-(2 ** (DATA_W - 1)));
   localparam logic [CW-1:0]        LAST    = CW'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_CALC = 2'd2,
      S_OUT  = 2'd3
   } state_t;

   state_t                    state_q, state_d;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic [CW-1:0]             idx_q, idx_d;
   logic [MODE_W-1:0]         mode_q, mode_d;
   logic                      out_valid_q, out_valid_d;
   logic [DATA_W-1:0]         out_data_q, out_data_d;
   logic                      err_q, err_d;

   logic signed [DATA_W-1:0]  x_q   [N];
   logic signed [DATA_W-1:0]  x_d   [N];
   logic signed [DATA_W-1:0]  asc_q [N];
   logic signed [DATA_W-1:0]  asc_d [N];
   logic signed [DATA_W-1:0]  dsc_q [N];
   logic signed [DATA_W-1:0]  dsc_d [N];
   logic signed [DATA_W-1:0]  res_q [N];
   logic signed [DATA_W-1:0]  res_d [N];

   logic signed [DATA_W-1:0]  asc_ins  [N];
   logic signed [DATA_W-1:0]  dsc_ins  [N];
   logic signed [DATA_W-1:0]  calc_res [N];

   logic signed [DATA_W-1:0]  in_word;
   logic signed [DATA_W-1:0]  prev_a, prev_d;
   logic                      a_gt_cur, a_gt_prev, d_lt_cur, d_lt_prev;
   logic signed [SW-1:0]      acc;
   logic signed [DATA_W-1:0]  run_max;
   logic signed [DATA_W-1:0]  min_v;
   logic                      mode_reserved;

   function automatic logic signed [DATA_W-1:0] sat_w(input logic signed [SW-1:0] v);
      if (v > SAT_MAX)      return SAT_MAX[DATA_W-1:0];
      else if (v < SAT_MIN) return SAT_MIN[DATA_W-1:0];
      else                  return v[DATA_W-1:0];
   endfunction

   assign in_word       = in_data;
   assign mode_reserved = (mode_q >= MODE_W'(7));

   // Stable insertion of the incoming word into two sorted banks holding cnt_q
   // valid entries. The new word lands after every entry that compares equal,
   // so ties keep arrival order in both the ascending and descending banks.
   // Entries at positions above the insertion point shift up by one.
   always_comb begin
      prev_a    = asc_q[0];
      prev_d    = dsc_q[0];
      a_gt_cur  = 1'b0;
      a_gt_prev = 1'b0;
      d_lt_cur  = 1'b0;
      d_lt_prev = 1'b0;
      for (int i = 0; i < N; i++) begin
         asc_ins[i] = asc_q[i];
         dsc_ins[i] = dsc_q[i];
         if (i <= int'(cnt_q)) begin
            prev_a    = asc_q[(i == 0) ? 0 : i - 1];
            prev_d    = dsc_q[(i == 0) ? 0 : i - 1];
            a_gt_cur  = (i < int'(cnt_q)) && (asc_q[i] > in_word);
            a_gt_prev = (i > 0) && (prev_a > in_word);
            d_lt_cur  = (i < int'(cnt_q)) && (dsc_q[i] < in_word);
            d_lt_prev = (i > 0) && (prev_d < in_word);
            if (a_gt_prev)
               asc_ins[i] = prev_a;
            else if (a_gt_cur || (i == int'(cnt_q)))
               asc_ins[i] = in_word;
            if (d_lt_prev)
               dsc_ins[i] = prev_d;
            else if (d_lt_cur || (i == int'(cnt_q)))
               dsc_ins[i] = in_word;
         end
      end
   end

   // Result vector for the latched mode, registered during CALC.
   always_comb begin
      acc     = '0;
      run_max = x_q[0];
      min_v   = asc_q[0];
      for (int i = 0; i < N; i++) calc_res[i] = x_q[i];
      case (mode_q)
         MODE_W'(1): for (int i = 0; i < N; i++) calc_res[i] = x_q[N-1-i];
         MODE_W'(2): for (int i = 0; i < N; i++) calc_res[i] = asc_q[i];
         MODE_W'(3): for (int i = 0; i < N; i++) calc_res[i] = dsc_q[i];
         MODE_W'(4): begin
            for (int i = 0; i < N; i++) begin
               acc         = acc + SW'(x_q[i]);
               calc_res[i] = sat_w(acc);
            end
         end
         MODE_W'(5): begin
            // The ascending bank's head is the frame minimum.
            for (int i = 0; i < N; i++)
               calc_res[i] = sat_w(SW'(x_q[i]) - SW'(min_v));
         end
         MODE_W'(6): begin
            for (int i = 0; i < N; i++) begin
               if (x_q[i] > run_max) run_max = x_q[i];
               calc_res[i] = run_max;
            end
         end
         default: ;
      endcase
   end

   // Next-state and output logic. Outputs are registered, so out_valid/out_data
   // trail the OUT state by one cycle; the last result beat is therefore shown
   // while the FSM is already back in IDLE, and a beat arriving in that cycle
   // is treated as a protocol error rather than a new frame.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      mode_d      = mode_q;
      x_d         = x_q;
      asc_d       = asc_q;
      dsc_d       = dsc_q;
      res_d       = res_q;
      out_valid_d = 1'b0;
      out_data_d  = '0;
      err_d       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               if (out_valid_q) begin
                  err_d = 1'b1;
               end else begin
                  x_d[0]  = in_word;
                  asc_d   = asc_ins;
                  dsc_d   = dsc_ins;
                  mode_d  = in_mode;
                  cnt_d   = CW'(1);
                  state_d = S_LOAD;
               end
            end
         end
         S_LOAD: begin
            if (in_valid) begin
               x_d[cnt_q] = in_word;
               asc_d      = asc_ins;
               dsc_d      = dsc_ins;
               if (cnt_q == LAST) begin
                  cnt_d   = '0;
                  state_d = S_CALC;
                  // Registered here so the pulse is visible during CALC.
                  err_d   = mode_reserved;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end else begin
               // Short frame: drop everything collected so far.
               cnt_d   = '0;
               err_d   = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_CALC: begin
            res_d   = calc_res;
            idx_d   = '0;
            err_d   = in_valid;
            state_d = S_OUT;
         end
         S_OUT: begin
            out_valid_d = 1'b1;
            out_data_d  = res_q[idx_q];
            err_d       = in_valid;
            if (idx_q == LAST) begin
               idx_d   = '0;
               state_d = S_IDLE;
            end else begin
               idx_d = idx_q + CW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         mode_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         err_q       <= 1'b0;
         for (int i = 0; i < N; i++) begin
            x_q[i]   <= '0;
            asc_q[i] <= '0;
            dsc_q[i] <= '0;
            res_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         mode_q      <= mode_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         err_q       <= err_d;
         x_q         <= x_d;
         asc_q       <= asc_d;
         dsc_q       <= dsc_d;
         res_q       <= res_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign err       = err_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_frame_mode_engine.sv
// -----------------------------------------------------------------------------
// tb_frame_mode_engine
//   Bench for frame_mode_engine (N=6, DATA_W=9): reset behaviour, a table of
//   known frames, hand-built multi-cycle corner sequences, and random frames
//   scored against a plain-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_frame_mode_engine;

   localparam int N      = 6;
   localparam int DATA_W = 9;
   localparam int MODE_W = 3;

   typedef logic [N-1:0][DATA_W-1:0] word_vec_t;
   typedef struct packed {
      logic [2:0] mode;
      word_vec_t  x;
      word_vec_t  y;
      logic [1:0] nerr;
   } vec_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic [DATA_W-1:0] in_data = '0;
   logic [MODE_W-1:0] in_mode = '0;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              err;
   logic [1:0]        dbg_state;

   int errors     = 0;
   int checks     = 0;
   int cyc        = 0;
   int err_seen   = 0;
   int err_base   = 0;
   int beats_seen = 0;
   bit prev_ov    = 1'b0;

   logic [DATA_W-1:0] exp_q[$];
   int                start_q[$];
   logic [DATA_W-1:0] mon_e;
   int                mon_s;

   vec_t vecs [9];

   frame_mode_engine #(.DATA_W(DATA_W), .N(N), .MODE_W(MODE_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_data  (out_data),
      .err       (err),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference model ----------------
   function automatic int clamp(input int v);
      if (v > 255)  return 255;
      if (v < -256) return -256;
      return v;
   endfunction

   function automatic word_vec_t model(input int mode, input word_vec_t xv);
      int x [N];
      int r [N];
      int t, s, m;
      word_vec_t y;
      for (int i = 0; i < N; i++) x[i] = int'($signed(xv[i]));
      for (int i = 0; i < N; i++) r[i] = x[i];
      case (mode)
         1: for (int i = 0; i < N; i++) r[i] = x[N-1-i];
         2, 3: begin
            // bubble sort swapping only strictly out-of-order pairs keeps ties stable
            for (int p = 0; p < N - 1; p++)
               for (int j = 0; j < N - 1 - p; j++)
                  if ((mode == 2) ? (r[j] > r[j+1]) : (r[j] < r[j+1])) begin
                     t = r[j]; r[j] = r[j+1]; r[j+1] = t;
                  end
         end
         4: begin
            s = 0;
            for (int i = 0; i < N; i++) begin s += x[i]; r[i] = clamp(s); end
         end
         5: begin
            m = x[0];
            for (int i = 1; i < N; i++) if (x[i] < m) m = x[i];
            for (int i = 0; i < N; i++) r[i] = clamp(x[i] - m);
         end
         6: begin
            m = x[0];
            for (int i = 0; i < N; i++) begin if (x[i] > m) m = x[i]; r[i] = m; end
         end
         default: ;
      endcase
      for (int i = 0; i < N; i++) y[i] = DATA_W'(r[i]);
      return y;
   endfunction

   function automatic word_vec_t pk(input int a0, a1, a2, a3, a4, a5);
      word_vec_t r;
      r[0] = DATA_W'(a0); r[1] = DATA_W'(a1); r[2] = DATA_W'(a2);
      r[3] = DATA_W'(a3); r[4] = DATA_W'(a4); r[5] = DATA_W'(a5);
      return r;
   endfunction

   function automatic vec_t mk(input int mode, input word_vec_t x, input word_vec_t y, input int nerr);
      vec_t v;
      v.mode = 3'(mode);
      v.x    = x;
      v.y    = y;
      v.nerr = 2'(nerr);
      return v;
   endfunction

   // ---------------- scoreboard / monitor (samples on falling edge) ----------------
   always @(negedge clk) begin
      if (err === 1'b1) err_seen++;
      if (out_valid === 1'b1) begin
         if (!prev_ov) begin
            checks++;
            if (start_q.size() == 0) begin
               errors++;
               $display("FAIL latency: out_valid rose at cycle %0d with no frame pending", cyc);
            end else begin
               mon_s = start_q.pop_front();
               if (cyc != mon_s) begin
                  errors++;
                  $display("FAIL latency: out_valid rose at cycle %0d, required %0d", cyc, mon_s);
               end
            end
         end
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL out_beat: unexpected beat data=%0d", $signed(out_data));
         end else begin
            mon_e = exp_q.pop_front();
            if (out_data !== mon_e) begin
               errors++;
               $display("FAIL out_data: got %0d required %0d", $signed(out_data), $signed(mon_e));
            end
         end
         beats_seen++;
      end else begin
         checks++;
         if (out_data !== '0) begin
            errors++;
            $display("FAIL idle_data: got %0d required 0 while out_valid=%b", $signed(out_data), out_valid);
         end
      end
      prev_ov = (out_valid === 1'b1);
   end

   // ---------------- driver tasks (inputs change at falling edge + 1) ----------------
   task automatic idle(input int n);
      repeat (n) begin @(negedge clk); #1; end
   endtask

   task automatic send_frame(input int mode, input word_vec_t xv, input int len);
      for (int b = 0; b < len; b++) begin
         in_valid = 1'b1;
         in_data  = xv[b];
         in_mode  = (b == 0) ? MODE_W'(mode) : MODE_W'($urandom_range(0, 7));
         @(negedge clk); #1;
      end
      in_valid = 1'b0;
      in_data  = DATA_W'($urandom_range(0, 511));
      in_mode  = MODE_W'($urandom_range(0, 7));
      // cyc now names the edge that sampled the last beat
      if (len == N) start_q.push_back(cyc + 2);
   endtask

   task automatic push_exp(input word_vec_t y);
      for (int i = 0; i < N; i++) exp_q.push_back(y[i]);
   endtask

   task automatic wait_done(input string name);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 60; k++) begin
         if (exp_q.size() == 0 && out_valid !== 1'b1) begin ok = 1'b1; break; end
         @(negedge clk); #1;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: timeout with %0d beats outstanding, required 0", name, exp_q.size());
         exp_q.delete();
         start_q.delete();
      end
   endtask

   task automatic wait_beats(input int target, input string name);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (beats_seen >= target) begin ok = 1'b1; break; end
         @(negedge clk); #1;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: saw %0d beats, required %0d", name, beats_seen, target);
      end
   endtask

   task automatic check_err(input string name, input int exp_n);
      checks++;
      if (err_seen - err_base != exp_n) begin
         errors++;
         $display("FAIL %s: err pulses %0d, required %0d", name, err_seen - err_base, exp_n);
      end
   endtask

   // ---------------- test sequence ----------------
   initial begin
      word_vec_t xv, yv;
      int        mode, n7, base, lo, hi;

      vecs[0] = mk(2, pk(5, -3, 255, 0, -256, 5),        pk(-256, -3, 0, 5, 5, 255), 0);
      vecs[1] = mk(4, pk(200, 100, -50, -255, 10, -256), pk(200, 255, 250, -5, 5, -251), 0);
      vecs[2] = mk(5, pk(-256, 255, 0, 1, 2, 3),         pk(0, 255, 255, 255, 255, 255), 0);
      vecs[3] = mk(6, pk(-256, 255, 0, 1, 2, 3),         pk(-256, 255, 255, 255, 255, 255), 0);
      vecs[4] = mk(3, pk(5, -3, 255, 0, -256, 5),        pk(255, 5, 5, 0, -3, -256), 0);
      vecs[5] = mk(1, pk(1, -2, 3, -4, 5, -6),           pk(-6, 5, -4, 3, -2, 1), 0);
      vecs[6] = mk(0, pk(7, -7, 100, -100, 0, 1),        pk(7, -7, 100, -100, 0, 1), 0);
      vecs[7] = mk(7, pk(9, 8, 7, 6, 5, 4),              pk(9, 8, 7, 6, 5, 4), 1);
      vecs[8] = mk(4, pk(-256, -256, -1, 0, 255, 255),   pk(-256, -256, -256, -256, -256, -3), 0);

      // reset held for two edges, then idle outputs must stay quiet
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk); #1;
      for (int c = 0; c < 5; c++) begin
         checks += 2;
         if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", out_valid); end
         if (err !== 1'b0)       begin errors++; $display("FAIL reset_err: got %b required 0", err); end
         @(negedge clk); #1;
      end

      // table-driven frames
      for (int i = 0; i < 9; i++) begin
         err_base = err_seen;
         push_exp(vecs[i].y);
         send_frame(int'(vecs[i].mode), vecs[i].x, N);
         wait_done("table_frame");
         idle(2);
         check_err("table_err", int'(vecs[i].nerr));
      end

      // short frame: 4 beats then drop, err the following cycle, no output
      err_base = err_seen;
      send_frame(2, pk(1, 2, 3, 4, 5, 6), 4);
      @(negedge clk); #1;
      checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL short_err_pulse: got %b required 1", err); end
      idle(4);
      check_err("short_err_count", 1);
      err_base = err_seen;
      xv = pk(-9, 4, -9, 100, 0, 4);
      push_exp(model(2, xv));
      send_frame(2, xv, N);
      wait_done("after_short");
      idle(2);
      check_err("after_short_err", 0);

      // back-to-back reverse frames with a one-cycle gap
      err_base = err_seen;
      xv = pk(10, 20, 30, 40, 50, 60);
      push_exp(pk(60, 50, 40, 30, 20, 10));
      send_frame(1, xv, N);
      wait_done("b2b_first");
      xv = pk(-1, -2, -3, -4, -5, -6);
      push_exp(pk(-6, -5, -4, -3, -2, -1));
      send_frame(1, xv, N);
      wait_done("b2b_second");
      idle(2);
      check_err("b2b_err", 0);

      // in_valid during OUT: two err pulses, stream untouched
      err_base = err_seen;
      base = beats_seen;
      xv = pk(3, -3, 33, -33, 0, 255);
      push_exp(xv);
      send_frame(0, xv, N);
      wait_beats(base + 1, "busy_wait");
      in_valid = 1'b1;
      in_data  = DATA_W'($urandom_range(0, 511));
      idle(2);
      in_valid = 1'b0;
      wait_done("busy_frame");
      idle(2);
      check_err("busy_err", 2);

      // reset during the third output beat: nothing more comes out
      base = beats_seen;
      xv = pk(50, -60, 70, -80, 90, -100);
      push_exp(model(2, xv));
      send_frame(2, xv, N);
      wait_beats(base + 3, "rst_wait");
      rst = 1'b1;
      exp_q.delete();
      start_q.delete();
      @(negedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out: out_valid got %b required 0", out_valid); end
      rst = 1'b0;
      err_base = err_seen;
      xv = pk(8, -8, 7, -7, 6, -6);
      push_exp(model(3, xv));
      send_frame(3, xv, N);
      wait_done("after_rst");
      idle(2);
      check_err("after_rst_err", 0);

      // random frames against the reference model
      err_base = err_seen;
      n7 = 0;
      for (int f = 0; f < 40; f++) begin
         mode = int'($urandom_range(0, 7));
         if ($urandom_range(0, 1) == 0) begin lo = -4; hi = 4; end
         else begin lo = -256; hi = 255; end
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 5) == 0)
               xv[i] = ($urandom_range(0, 1) == 0) ? DATA_W'(255) : DATA_W'(-256);
            else
               xv[i] = DATA_W'(lo + int'($urandom_range(0, hi - lo)));
         end
         if (mode == 7) n7++;
         yv = model(mode, xv);
         push_exp(yv);
         send_frame(mode, xv, N);
         wait_done("random_frame");
         idle(int'($urandom_range(0, 2)));
      end
      idle(2);
      check_err("random_err", n7);

      idle(3);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
